// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer
//   Three-channel LED PWM generator feeding the RGB0PWM/RGB1PWM/RGB2PWM inputs
//   of the SB_RGBA_DRV. A shared free-running counter of PWM_BITS bits defines
//   the PWM period. Mode and duties are sampled into shadow registers only at
//   the period boundary, so an output never changes shape mid-period.
//   Modes: OFF (dark), SOLID (duty), BLINK (duty gated by a HALF-cycle phase),
//   BREATHE (duty scaled by a triangle envelope stepping every STEP_CYCLES).
//
// Ports
//   clk_20Mhz     in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   mode          in   2'b00 OFF, 2'b01 SOLID, 2'b10 BLINK, 2'b11 BREATHE
//   duty_red      in   red duty (0 = dark)
//   duty_green    in   green duty
//   duty_blue     in   blue duty
//   pwm_red       out  to RGB0PWM
//   pwm_green     out  to RGB1PWM
//   pwm_blue      out  to RGB2PWM
//   period_start  out  one-cycle pulse while the PWM counter reads 0
module rgb_pwm_sequencer #(
  parameter int CLK_HZ      = 20000000,
  parameter int BLINK_HZ    = 1,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 4096
) (
  input  logic                clk_20Mhz,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty_red,
  input  logic [PWM_BITS-1:0] duty_green,
  input  logic [PWM_BITS-1:0] duty_blue,
  output logic                pwm_red,
  output logic                pwm_green,
  output logic                pwm_blue,
  output logic                period_start
);

  localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 2) ? 2 : HALF_RAW;
  localparam int STEPS    = (STEP_CYCLES < 1) ? 1 : STEP_CYCLES;
  localparam int PRE_W    = $clog2(HALF);
  localparam int STEP_W   = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);
  localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(HALF - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [STEP_W-1:0]   STEP_MAX = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0]   STEP_ONE = STEP_W'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_SOLID   = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PWM_BITS-1:0]       cnt_reg, cnt_next;
  mode_t                     mode_reg, mode_next;
  logic [2:0][PWM_BITS-1:0]  duty_reg, duty_next;
  logic [PRE_W-1:0]          pre_reg, pre_next;
  logic                      phase_reg, phase_next;
  logic [STEP_W-1:0]         step_reg, step_next;
  logic [PWM_BITS-1:0]       env_reg, env_next;
  dir_t                      dir_reg, dir_next;
  logic [2:0]                pwm_reg, pwm_next;
  logic                      period_start_reg, period_start_next;

  logic                      boundary;
  mode_t                     mode_in;
  logic [2:0][PWM_BITS-1:0]  duty_in;

  // Channel index 0 = red, 1 = green, 2 = blue.
  assign duty_in  = {duty_blue, duty_green, duty_red};
  assign mode_in  = mode_t'(mode);
  assign boundary = (cnt_reg == CNT_MAX);

  // Sequencing: counter, shadow registers, blink prescaler and envelope.
  always_comb begin
    cnt_next          = cnt_reg + CNT_ONE;
    period_start_next = boundary;
    mode_next         = mode_reg;
    duty_next         = duty_reg;
    pre_next          = '0;
    phase_next        = phase_reg;
    step_next         = '0;
    env_next          = env_reg;
    dir_next          = dir_reg;

    if (mode_reg == MODE_BLINK) begin
      if (pre_reg == PRE_MAX) begin
        phase_next = ~phase_reg;
      end else begin
        pre_next = pre_reg + PRE_ONE;
      end
    end

    if (mode_reg == MODE_BREATHE) begin
      if (step_reg == STEP_MAX) begin
        // Endpoints bounce immediately so each one lasts a single step.
        if (dir_reg == DIR_UP) begin
          if (env_reg == CNT_MAX) begin
            env_next = CNT_MAX - CNT_ONE;
            dir_next = DIR_DOWN;
          end else begin
            env_next = env_reg + CNT_ONE;
          end
        end else begin
          if (env_reg == '0) begin
            env_next = CNT_ONE;
            dir_next = DIR_UP;
          end else begin
            env_next = env_reg - CNT_ONE;
          end
        end
      end else begin
        step_next = step_reg + STEP_ONE;
      end
    end

    if (boundary) begin
      mode_next = mode_in;
      duty_next = duty_in;
      // A new mode restarts blink and breathe from a known phase;
      // re-latching the same mode lets them run on undisturbed.
      if (mode_in != mode_reg) begin
        pre_next   = '0;
        phase_next = 1'b1;
        step_next  = '0;
        env_next   = '0;
        dir_next   = DIR_UP;
      end
    end
  end

  // Per-channel effective duty and comparator.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [PWM_BITS-1:0] eff_breathe;
    logic [PWM_BITS-1:0] eff;

    // Full 2N-bit product, upper half kept (truncating scale by env/2^N).
    assign eff_breathe = PWM_BITS'(({{PWM_BITS{1'b0}}, duty_reg[gi]} *
                                    {{PWM_BITS{1'b0}}, env_reg}) >> PWM_BITS);

    always_comb begin
      eff = '0;
      case (mode_reg)
        MODE_SOLID:   eff = duty_reg[gi];
        MODE_BLINK:   eff = phase_reg ? duty_reg[gi] : '0;
        MODE_BREATHE: eff = eff_breathe;
        default:      eff = '0;
      endcase
    end

    assign pwm_next[gi] = (cnt_reg < eff);
  end

  always_ff @(posedge clk_20Mhz or posedge rst) begin
    if (rst) begin
      cnt_reg          <= '0;
      mode_reg         <= MODE_OFF;
      duty_reg         <= '0;
      pre_reg          <= '0;
      phase_reg        <= 1'b1;
      step_reg         <= '0;
      env_reg          <= '0;
      dir_reg          <= DIR_UP;
      pwm_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= cnt_next;
      mode_reg         <= mode_next;
      duty_reg         <= duty_next;
      pre_reg          <= pre_next;
      phase_reg        <= phase_next;
      step_reg         <= step_next;
      env_reg          <= env_next;
      dir_reg          <= dir_next;
      pwm_reg          <= pwm_next;
      period_start_reg <= period_start_next;
    end
  end

  assign pwm_red      = pwm_reg[0];
  assign pwm_green    = pwm_reg[1];
  assign pwm_blue     = pwm_reg[2];
  assign period_start = period_start_reg;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Testbench for rgb_pwm_sequencer.
// Three instances: A (PWM_BITS=4, solid/duty/update tests), B (HALF=10,
// PWM_BITS=2, blink), C (PWM_BITS=3, STEP_CYCLES=16, breathe + async reset).
// Expected per-period waveforms are queued up front; a monitor rebuilds each
// period's waveform (bit i = output driven from counter value i) and checks it
// against the queue each time period_start is seen.
module tb_rgb_pwm_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v = 3'b111;

  logic [1:0] mode_a = 2'b00;
  logic [3:0] dr_a = '0, dg_a = '0, db_a = '0;
  logic       pwm_red_a, pwm_green_a, pwm_blue_a, period_start_a;

  logic [1:0] mode_b = 2'b00;
  logic [1:0] dr_b = '0, dg_b = '0, db_b = '0;
  logic       pwm_red_b, pwm_green_b, pwm_blue_b, period_start_b;

  logic [1:0] mode_c = 2'b00;
  logic [2:0] dr_c = '0, dg_c = '0, db_c = '0;
  logic       pwm_red_c, pwm_green_c, pwm_blue_c, period_start_c;

  rgb_pwm_sequencer #(.PWM_BITS(4)) dut_a (
    .clk_20Mhz(clk), .rst(rst_v[0]), .mode(mode_a),
    .duty_red(dr_a), .duty_green(dg_a), .duty_blue(db_a),
    .pwm_red(pwm_red_a), .pwm_green(pwm_green_a), .pwm_blue(pwm_blue_a),
    .period_start(period_start_a)
  );

  rgb_pwm_sequencer #(.CLK_HZ(1000), .BLINK_HZ(50), .PWM_BITS(2)) dut_b (
    .clk_20Mhz(clk), .rst(rst_v[1]), .mode(mode_b),
    .duty_red(dr_b), .duty_green(dg_b), .duty_blue(db_b),
    .pwm_red(pwm_red_b), .pwm_green(pwm_green_b), .pwm_blue(pwm_blue_b),
    .period_start(period_start_b)
  );

  rgb_pwm_sequencer #(.PWM_BITS(3), .STEP_CYCLES(16)) dut_c (
    .clk_20Mhz(clk), .rst(rst_v[2]), .mode(mode_c),
    .duty_red(dr_c), .duty_green(dg_c), .duty_blue(db_c),
    .pwm_red(pwm_red_c), .pwm_green(pwm_green_c), .pwm_blue(pwm_blue_c),
    .period_start(period_start_c)
  );

  logic [2:0] pwm_v [3];
  logic [2:0] ps_v;
  assign pwm_v[0] = {pwm_blue_a, pwm_green_a, pwm_red_a};
  assign pwm_v[1] = {pwm_blue_b, pwm_green_b, pwm_red_b};
  assign pwm_v[2] = {pwm_blue_c, pwm_green_c, pwm_red_c};
  assign ps_v     = {period_start_c, period_start_b, period_start_a};

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int r, input int g, input int b);
    exp_t e;
    e.r = 16'(r);
    e.g = 16'(g);
    e.b = 16'(b);
    return e;
  endfunction

  function automatic int ones(input int n);
    return (1 << n) - 1;
  endfunction

  function automatic int plen(input int d);
    case (d)
      0:       return 16;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic string dname(input int d);
    case (d)
      0:       return "solid";
      1:       return "blink";
      default: return "breathe";
    endcase
  endfunction

  function automatic bit pop_exp(input int d, output exp_t e);
    e = '0;
    case (d)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); return 1'b1; end
      1: if (q_b.size() > 0) begin e = q_b.pop_front(); return 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  // Waits for n period_start pulses on instance d, each bounded.
  task automatic wait_pulses(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!ps_v[d] && t < 64);
      check({dname(d), "_pulse_seen"}, int'(ps_v[d]), 1);
    end
  endtask

  // Monitor: one waveform per period, compared at each period_start.
  initial begin
    int          idx [3];
    logic [15:0] pr [3];
    logic [15:0] pg [3];
    logic [15:0] pb [3];
    exp_t        e;
    for (int d = 0; d < 3; d++) begin
      idx[d] = 0; pr[d] = '0; pg[d] = '0; pb[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst_v[d]) begin
          idx[d] = 0; pr[d] = '0; pg[d] = '0; pb[d] = '0;
        end else begin
          if (idx[d] < 16) begin
            pr[d][idx[d]] = pwm_v[d][0];
            pg[d][idx[d]] = pwm_v[d][1];
            pb[d][idx[d]] = pwm_v[d][2];
          end
          if (ps_v[d]) begin
            if (pop_exp(d, e)) begin
              check({dname(d), "_spacing"}, idx[d], plen(d) - 1);
              check({dname(d), "_red"},   int'(pr[d]), int'(e.r));
              check({dname(d), "_green"}, int'(pg[d]), int'(e.g));
              check({dname(d), "_blue"},  int'(pb[d]), int'(e.b));
              $display("[%0t] %s period: red=%h green=%h blue=%h", $time,
                       dname(d), pr[d], pg[d], pb[d]);
            end
            idx[d] = 0; pr[d] = '0; pg[d] = '0; pb[d] = '0;
          end else begin
            idx[d]++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Breathe tables per envelope step (env 0,1,..,7,6,..,0,1):
  // red duty 4 -> (4*env)>>3, blue duty 7 -> (7*env)>>3.
  int br_red  [16] = '{0,0,1,1,2,2,3,3,3,2,2,1,1,0,0,0};
  int br_blue [16] = '{0,0,1,2,3,4,5,6,5,4,3,2,1,0,0,0};

  initial begin
    // ---------------- Instance A: reset, extremes, glitch-free update
    mode_a = 2'b01; dr_a = 4'd8; dg_a = 4'd0; db_a = 4'd15;
    q_a.push_back(mk(0, 0, 0));                       // OFF after reset
    for (int k = 0; k < 10; k++) q_a.push_back(mk(16'h00FF, 0, 16'h7FFF));
    q_a.push_back(mk(16'h000F, 0, 16'h7FFF));         // red 4
    q_a.push_back(mk(16'h0FFF, 0, 16'h7FFF));         // red 12
    q_a.push_back(mk(16'h0FFF, 0, 16'h7FFF));         // transient ignored
    q_a.push_back(mk(0, 0, 0));                       // OFF again
    repeat (20) @(negedge clk);
    check("solid_rst_red", int'(pwm_red_a), 0);
    check("solid_rst_blue", int'(pwm_blue_a), 0);
    check("solid_rst_pstart", int'(period_start_a), 0);
    #1 rst_v[0] = 1'b0;
    wait_pulses(0, 10);
    dr_a = 4'd4;
    wait_pulses(0, 1);
    repeat (6) @(negedge clk);
    dr_a = 4'd12;                                     // mid-period change
    wait_pulses(0, 1);
    repeat (3) @(negedge clk);
    dr_a = 4'd1; mode_a = 2'b00;
    repeat (5) @(negedge clk);
    dr_a = 4'd12; mode_a = 2'b01;                     // restored in-period
    wait_pulses(0, 1);
    mode_a = 2'b00;
    wait_pulses(0, 2);

    // ---------------- Instance B: blink, HALF = 10, period 4
    mode_b = 2'b10; dr_b = 2'd3; dg_b = 2'd0; db_b = 2'd1;
    q_b.push_back(mk(0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      q_b.push_back(mk(4'b0111, 0, 4'b0001));
      q_b.push_back(mk(4'b0111, 0, 4'b0001));
      q_b.push_back(mk(4'b0011, 0, 4'b0001));
      q_b.push_back(mk(0, 0, 0));
      q_b.push_back(mk(0, 0, 0));
    end
    @(negedge clk);
    #1 rst_v[1] = 1'b0;
    wait_pulses(1, 11);

    // ---------------- Instance C: breathe, then async reset mid-period
    mode_c = 2'b11; dr_c = 3'd4; dg_c = 3'd0; db_c = 3'd7;
    q_c.push_back(mk(0, 0, 0));
    for (int s = 0; s < 16; s++) begin
      q_c.push_back(mk(ones(br_red[s]), 0, ones(br_blue[s])));
      q_c.push_back(mk(ones(br_red[s]), 0, ones(br_blue[s])));
    end
    @(negedge clk);
    #1 rst_v[2] = 1'b0;
    wait_pulses(2, 33);
    @(negedge clk);                                   // env 2: both lit at cnt 0
    check("breathe_pre_red", int'(pwm_red_c), 1);
    check("breathe_pre_blue", int'(pwm_blue_c), 1);
    #2 rst_v[2] = 1'b1;                               // between clock edges
    #1;
    check("breathe_arst_red", int'(pwm_red_c), 0);
    check("breathe_arst_blue", int'(pwm_blue_c), 0);
    check("breathe_arst_pstart", int'(period_start_c), 0);
    // After release: OFF period, then envelope restarts at 0.
    q_c.push_back(mk(0, 0, 0));
    q_c.push_back(mk(0, 0, 0));
    q_c.push_back(mk(0, 0, 0));
    q_c.push_back(mk(0, 0, 0));
    q_c.push_back(mk(0, 0, 0));
    q_c.push_back(mk(1, 0, 1));
    q_c.push_back(mk(1, 0, 1));
    repeat (3) @(negedge clk);
    #1 rst_v[2] = 1'b0;
    wait_pulses(2, 7);

    @(negedge clk);
    check("queue_solid_left", q_a.size(), 0);
    check("queue_blink_left", q_b.size(), 0);
    check("queue_breathe_left", q_c.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
